// File: rtl/regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : regs_if
//  Brief    : Write, read and debug port bundle for the RV32I register file.
//  Revision : 1.0
// ============================================================================
interface regs_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] reg_waddr_i;
    logic [XLEN-1:0]   reg_wdata_i;
    logic              reg_wen_i;
    logic [ADDR_W-1:0] rs1_raddr_i;
    logic [ADDR_W-1:0] rs2_raddr_i;
    logic [XLEN-1:0]   rs1_rdata_o;
    logic [XLEN-1:0]   rs2_rdata_o;
    logic [ADDR_W-1:0] dbg_raddr_i;
    logic [XLEN-1:0]   dbg_rdata_o;
    logic [31:0]       wr_count_o;

    modport master (
        output reg_waddr_i,
        output reg_wdata_i,
        output reg_wen_i,
        output rs1_raddr_i,
        output rs2_raddr_i,
        output dbg_raddr_i,
        input  rs1_rdata_o,
        input  rs2_rdata_o,
        input  dbg_rdata_o,
        input  wr_count_o
    );

    modport slave (
        input  reg_waddr_i,
        input  reg_wdata_i,
        input  reg_wen_i,
        input  rs1_raddr_i,
        input  rs2_raddr_i,
        input  dbg_raddr_i,
        output rs1_rdata_o,
        output rs2_rdata_o,
        output dbg_rdata_o,
        output wr_count_o
    );
endinterface
`default_nettype wire

// File: rtl/regs.sv
`default_nettype none
// ============================================================================
//  Module   : regs
//  Brief    : RV32I register file, two bypassed combinational read ports,
//             registered debug read port and committed-write counter.
//  Revision : 1.0
// ============================================================================
module regs #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    regs_if.slave     bus
);
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] c_X0 = '0;

    // x0 is hard-wired, so storage only exists for x1..x(NREG-1)
    logic [XLEN-1:0] r_mem [1:NREG-1];
    logic [XLEN-1:0] r_dbg_rdata;
    logic [31:0]     r_wr_count;

    logic            w_commit;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic [XLEN-1:0] w_rs1_rdata;
    logic [XLEN-1:0] w_rs2_rdata;

    assign w_commit = bus.reg_wen_i && (bus.reg_waddr_i != c_X0);

    // Address compare is independent of storage so the bypass is one 2:1 level
    assign w_rs1_hit = bus.reg_wen_i && (bus.reg_waddr_i == bus.rs1_raddr_i);
    assign w_rs2_hit = bus.reg_wen_i && (bus.reg_waddr_i == bus.rs2_raddr_i);

    always_comb begin
        w_rs1_rdata = '0;
        if (bus.rs1_raddr_i != c_X0) begin
            w_rs1_rdata = w_rs1_hit ? bus.reg_wdata_i : r_mem[bus.rs1_raddr_i];
        end
    end

    always_comb begin
        w_rs2_rdata = '0;
        if (bus.rs2_raddr_i != c_X0) begin
            w_rs2_rdata = w_rs2_hit ? bus.reg_wdata_i : r_mem[bus.rs2_raddr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_dbg_rdata <= '0;
            r_wr_count  <= '0;
        end else begin
            if (w_commit) begin
                r_mem[bus.reg_waddr_i] <= bus.reg_wdata_i;
                r_wr_count             <= r_wr_count + 32'd1;
            end
            // Debug sees pre-write storage: a write at edge N shows after N+1
            r_dbg_rdata <= (bus.dbg_raddr_i == c_X0) ? '0 : r_mem[bus.dbg_raddr_i];
        end
    end

    assign bus.rs1_rdata_o = w_rs1_rdata;
    assign bus.rs2_rdata_o = w_rs2_rdata;
    assign bus.dbg_rdata_o = r_dbg_rdata;
    assign bus.wr_count_o  = r_wr_count;
endmodule
`default_nettype wire

// File: tb/tb_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regs
//  Brief    : Directed self-checking bench for the regs register file.
//  Revision : 1.0
// ============================================================================
module tb_regs;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regs_if #(.XLEN(32), .ADDR_W(5)) bus ();

    regs #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.reg_wen_i   = 1'b1;
        bus.reg_waddr_i = a;
        bus.reg_wdata_i = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst              = 1'b1;
        bus.reg_wen_i    = 1'b0;
        bus.reg_waddr_i  = '0;
        bus.reg_wdata_i  = '0;
        bus.rs1_raddr_i  = 5'd5;
        bus.rs2_raddr_i  = 5'd31;
        bus.dbg_raddr_i  = 5'd5;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_cnt", bus.wr_count_o, 32'h0);
        check("reset_dbg", bus.dbg_rdata_o, 32'h0);
        check("reset_rs1", bus.rs1_rdata_o, 32'h0);
        check("reset_rs2", bus.rs2_rdata_o, 32'h0);

        // Reset clears a written register
        wr(5'd5, 32'hDEAD_BEEF);
        tick();
        bus.reg_wen_i = 1'b0;
        #1;
        check("x5_written", bus.rs1_rdata_o, 32'hDEAD_BEEF);
        check("cnt_one", bus.wr_count_o, 32'd1);
        tick();
        check("dbg_x5", bus.dbg_rdata_o, 32'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("x5_cleared", bus.rs1_rdata_o, 32'h0);
        check("cnt_cleared", bus.wr_count_o, 32'h0);
        check("dbg_cleared", bus.dbg_rdata_o, 32'h0);
        tick();
        check("dbg_after_rst", bus.dbg_rdata_o, 32'h0);

        // Basic back-to-back writes
        wr(5'd1, 32'h0000_0010);
        tick();
        wr(5'd31, 32'hFFFF_FFF0);
        tick();
        bus.reg_wen_i   = 1'b0;
        bus.rs1_raddr_i = 5'd1;
        bus.rs2_raddr_i = 5'd31;
        #1;
        check("rd_x1", bus.rs1_rdata_o, 32'h0000_0010);
        check("rd_x31", bus.rs2_rdata_o, 32'hFFFF_FFF0);
        check("cnt_two", bus.wr_count_o, 32'd2);

        // x0 write is discarded
        wr(5'd0, 32'h1234_5678);
        bus.rs1_raddr_i = 5'd0;
        bus.rs2_raddr_i = 5'd0;
        #1;
        check("x0_same_rs1", bus.rs1_rdata_o, 32'h0);
        check("x0_same_rs2", bus.rs2_rdata_o, 32'h0);
        tick();
        bus.reg_wen_i = 1'b0;
        #1;
        check("x0_next_rs1", bus.rs1_rdata_o, 32'h0);
        check("x0_next_rs2", bus.rs2_rdata_o, 32'h0);
        check("x0_cnt", bus.wr_count_o, 32'd2);

        // Bypass on both ports, then with enable dropped
        wr(5'd7, 32'h0000_0001);
        tick();
        wr(5'd7, 32'hAAAA_5555);
        bus.rs1_raddr_i = 5'd7;
        bus.rs2_raddr_i = 5'd7;
        #1;
        check("byp_rs1", bus.rs1_rdata_o, 32'hAAAA_5555);
        check("byp_rs2", bus.rs2_rdata_o, 32'hAAAA_5555);
        bus.rs2_raddr_i = 5'd1;
        #1;
        check("byp_only_rs1", bus.rs1_rdata_o, 32'hAAAA_5555);
        check("nobyp_rs2", bus.rs2_rdata_o, 32'h0000_0010);
        bus.rs2_raddr_i = 5'd7;
        bus.reg_wen_i   = 1'b0;
        #1;
        check("nowen_rs1", bus.rs1_rdata_o, 32'h0000_0001);
        check("nowen_rs2", bus.rs2_rdata_o, 32'h0000_0001);
        check("byp_cnt", bus.wr_count_o, 32'd3);

        // Debug port sees storage before the same-edge write
        wr(5'd3, 32'h0000_0099);
        bus.dbg_raddr_i = 5'd3;
        tick();
        wr(5'd3, 32'h0000_0055);
        tick();
        bus.reg_wen_i = 1'b0;
        check("dbg_old", bus.dbg_rdata_o, 32'h0000_0099);
        tick();
        check("dbg_new", bus.dbg_rdata_o, 32'h0000_0055);
        check("dbg_cnt", bus.wr_count_o, 32'd5);
        bus.dbg_raddr_i = 5'd0;
        tick();
        check("dbg_x0", bus.dbg_rdata_o, 32'h0);

        // Counter wrap via back-door preload while the clock is low
        @(negedge clk);
        dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        wr(5'd10, 32'h0000_0001);
        tick();
        check("wrap_zero", bus.wr_count_o, 32'h0000_0000);
        wr(5'd11, 32'h0000_0002);
        tick();
        check("wrap_one", bus.wr_count_o, 32'h0000_0001);

        // Reset in the middle of a back-to-back write stream
        bus.dbg_raddr_i = 5'd12;
        wr(5'd12, 32'h0000_0003);
        tick();
        wr(5'd13, 32'h0000_0004);
        rst = 1'b1;
        bus.rs1_raddr_i = 5'd13;
        bus.rs2_raddr_i = 5'd12;
        #1;
        check("rst_bypass", bus.rs1_rdata_o, 32'h0000_0004);
        check("rst_pre_x12", bus.rs2_rdata_o, 32'h0000_0003);
        tick();
        rst = 1'b0;
        bus.reg_wen_i = 1'b0;
        #1;
        check("rst_x13_dropped", bus.rs1_rdata_o, 32'h0);
        check("rst_x12_cleared", bus.rs2_rdata_o, 32'h0);
        check("rst_cnt", bus.wr_count_o, 32'h0);
        check("rst_dbg", bus.dbg_rdata_o, 32'h0);
        bus.rs1_raddr_i = 5'd31;
        bus.rs2_raddr_i = 5'd7;
        #1;
        check("rst_x31", bus.rs1_rdata_o, 32'h0);
        check("rst_x7", bus.rs2_rdata_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regs.md
# regs

General-purpose register file for the RV32I pipeline core. It holds architectural registers x0–x31 and supplies two combinational read ports to the decode stage. It accepts one write per cycle from the execute stage's `rd_addr_o` / `rd_data_o` / `rd_wen_o` outputs. It includes write-to-read bypass so decode sees a value in the same cycle execute produces it, plus a registered debug read port and a retired-write counter for the testbench.

## Interface
Parameters:
- `XLEN`, 32, register data width
- `NREG`, 32, number of architectural registers; address width is 5 bits

Ports:
- `clk`  input  1  core clock; all state updates on rising edge
- `rst`  input  1  synchronous reset, active-high
- `reg_waddr_i`  input  5  write address, driven by execute `rd_addr_o`
- `reg_wdata_i`  input  32  write data, driven by execute `rd_data_o`
- `reg_wen_i`  input  1  write enable, driven by execute `rd_wen_o`
- `rs1_raddr_i`  input  5  read port 1 address, from decode
- `rs2_raddr_i`  input  5  read port 2 address, from decode
- `rs1_rdata_o`  output  32  read port 1 data, combinational
- `rs2_rdata_o`  output  32  read port 2 data, combinational
- `dbg_raddr_i`  input  5  debug read address
- `dbg_rdata_o`  output  32  debug read data, registered
- `wr_count_o`  output  32  number of committed writes since reset

## Operation
- Storage is 31 registers of 32 bits for x1–x31. x0 has no storage and always reads 0.
- **Write commit:** on a rising edge with `rst`=0, `reg_wen_i`=1 and `reg_waddr_i`≠0, `mem[reg_waddr_i]` ← `reg_wdata_i`, and `wr_count_o` increments by 1.
- **x0 write:** a write to x0 with `reg_wen_i`=1 is discarded. No storage changes and `wr_count_o` does not increment.
- **Counter wrap:** `wr_count_o` wraps from 0xFFFF_FFFF to 0.
- **Read ports:** each read port evaluates in this priority order:
  1. If the read address is 0, the output is 0.
  2. Else, if `reg_wen_i`=1 and `reg_waddr_i` equals the read address, the output is `reg_wdata_i` (bypass).
  3. Else, the output is `mem[raddr]`.
- **Simultaneous reads:** both read ports may target the same register, and each applies the bypass independently.
- **Bypass during reset:** bypass is purely combinational and stays active while `rst`=1. The bypassed value is not committed during reset.
- **Debug port:** on each rising edge, `dbg_rdata_o` ← (`dbg_raddr_i`==0 ? 0 : `mem[dbg_raddr_i]`). It samples storage before any same-edge write, with no bypass. A write at edge N is visible on the debug port after edge N+1.
- **Reset:** while `rst`=1 at a rising edge:
  - all of x1–x31 are cleared to 0;
  - `dbg_rdata_o` is cleared to 0;
  - `wr_count_o` is cleared to 0;
  - writes presented in that cycle are dropped.
- **Reset mid-stream:** reset may assert at any cycle, and the result equals a fresh reset. Reads on the cycle after reset deassertion return 0 for every register unless bypassed.

## Timing
- Write latency: a write presented in cycle N is stored at the end of cycle N. A plain (non-bypassed) read returns it from cycle N+1.
- Read latency: 0 cycles (combinational from address and write inputs).
- Debug latency: 1 cycle from `dbg_raddr_i` to `dbg_rdata_o`.
- Reset values: `rs1_rdata_o` and `rs2_rdata_o` read 0 unless bypassed. `dbg_rdata_o`=0 and `wr_count_o`=0.
- No handshake: the write port is accepted unconditionally every cycle. The upstream pipeline is responsible for deasserting `reg_wen_i` on flushed or held instructions.
- Critical path: execute adder → `reg_wdata_i` → bypass mux → `rs*_rdata_o` → decode operand mux. The bypass mux is a single 2:1 level after the address compare.

## Test plan
- **Reset clear:** write 0xDEADBEEF to x5, pulse `rst` for 1 cycle, read x5 → 0. Expect `wr_count_o`=0 and `dbg_rdata_o`=0 after the reset edge.
- **Basic write/read:** write 0x0000_0010 to x1 at cycle N and 0xFFFF_FFF0 to x31 at cycle N+1. At N+2, read `rs1`=x1 and `rs2`=x31 → 0x10 and 0xFFFFFFF0. Expect `wr_count_o`=2.
- **x0 protection:** write 0x1234_5678 to x0 with `reg_wen_i`=1, and read x0 on both ports in the same and next cycle → 0. Expect `wr_count_o` unchanged.
- **Bypass:** x7 holds 0x1. In one cycle, present a write of 0xAAAA_5555 to x7 with `rs1`=`rs2`=x7 → both outputs 0xAAAA5555. Repeat with `reg_wen_i`=0 → both outputs 0x1.
- **Debug port ordering:** write 0x55 to x3 at cycle N with `dbg_raddr_i`=3 held. Expect `dbg_rdata_o` = old value after edge N and 0x55 after edge N+1.
- **Reset mid-stream plus counter wrap:** force `wr_count_o` near 0xFFFFFFFF via a back-door/preload, then write 2 times → 0x0000_0000 then 0x0000_0001. Assert `rst` during a back-to-back write sequence → that write is dropped and all outputs return to 0.
